egress_tx_arb: RTL
==================

# egress_tx_arb

Packet-granular round-robin arbiter that shares the single PCIe transmit AXIS datapath among N internal TLP sources (completer, DMA read-request, DMA write engines).

- Grants one requester at a time and holds the grant until that requester's end-of-packet beat is accepted, so TLPs are never interleaved.
- Drives a registered output stage in the same sop/eop/tkeep format the ingress side produces.
- Exposes debug counters for the config register space.

## Interface

Parameters:
- `N_REQ`, 3: number of requesters (2..8).
- `DATA_W`, 64: beat width in bits; equals PCIe core data width.
- `KEEP_W`, `DATA_W/8`: byte-enable width.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `s_axis_tvalid`  in  N_REQ  per-requester beat valid.
- `s_axis_tready`  out  N_REQ  per-requester ready; at most one bit high.
- `s_axis_tdata`  in  N_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- `s_axis_tkeep`  in  N_REQ*KEEP_W  packed the same way as tdata.
- `s_axis_tlast`  in  N_REQ  end-of-packet flag per requester.
- `m_axis_tx_tready`  in  1  downstream ready.
- `m_axis_tx_tvalid`  out  1  output beat valid.
- `m_axis_tx_tdata`  out  DATA_W  output data.
- `m_axis_tx_tkeep`  out  KEEP_W  output byte enables.
- `m_axis_tx_sop`  out  1  first beat of packet.
- `m_axis_tx_eop`  out  1  last beat of packet.
- `arb_grant`  out  N_REQ  one-hot current grant; 0 when idle.
- `arb_busy`  out  1  high while a packet is being forwarded.
- `tx_pkt_cnt`  out  32  count of eop beats accepted downstream; wraps modulo 2^32.

## Operation

- FSM states: IDLE and BUSY. Reset state is IDLE.
- **IDLE:**
  - If any `s_axis_tvalid` bit is set, select the first valid requester searching upward (with wrap) from `last_grant+1`.
  - Register the selection into `arb_grant`, set `arb_busy`, and go to BUSY.
  - `s_axis_tready` is 0 in IDLE.
  - The tvalid vector is sampled only in IDLE; valid changes in BUSY do not affect the current grant.
- **BUSY with grant g:**
  - `s_axis_tready[g] = ~m_axis_tx_tvalid | m_axis_tx_tready`; all other ready bits are 0.
  - An input handshake on g loads tdata, tkeep, and tlast into the output register.
  - `m_axis_tx_sop` is set if this is the first handshake since the grant; `m_axis_tx_eop` is set to tlast.
  - The input handshake on the tlast beat clears `arb_grant` and `arb_busy`, stores g in `last_grant`, and returns to IDLE.
- **Output register:**
  - `m_axis_tx_tvalid` sets on an input handshake.
  - It clears on a downstream handshake with no simultaneous input handshake.
  - Data, keep, sop, and eop hold while tvalid is high and tready is low.
- **Requester rules:**
  - A requester deasserting tvalid mid-packet keeps the grant; the arbiter waits indefinitely.
  - Requester sop is not an input. Packet boundaries come from tlast only.
- **Fairness:** `last_grant` resets to N_REQ-1, so requester 0 has first priority after reset.
- **`tx_pkt_cnt`:** increments when `m_axis_tx_tvalid & m_axis_tx_tready & m_axis_tx_eop`.
- **Reset:** a reset mid-packet discards the in-flight beat and the partial packet.
  - No recovery is attempted.
  - Requesters are responsible for re-sending.

## Timing

- Reset value is 0 for every output: tready, tvalid, tdata, tkeep, sop, eop, arb_grant, arb_busy, and tx_pkt_cnt.
- Arbitration latency:
  - Requester valid in IDLE at cycle T gives grant and `s_axis_tready` at T+1 (assuming the output is empty or downstream is ready).
  - The first beat appears on `m_axis_tx_tvalid` at T+2.
- Data latency is one cycle from input handshake to output valid.
- Throughput:
  - One beat per cycle within a packet under continuous downstream ready.
  - One bubble cycle (the IDLE arbitration cycle) between packets.
- A single-beat packet (tlast on the first beat) has sop=1 and eop=1 on the same output beat. The FSM returns to IDLE the cycle after the handshake.
- Backpressure: with `m_axis_tx_tready` low and the output full, `s_axis_tready[g]` is 0 in the same cycle (combinational path from downstream ready).
- Simultaneous downstream handshake and input handshake in the same cycle: the output register reloads and tvalid stays 1.

## Test plan

- **Single requester:** requester 0 sends a 4-beat packet, tdata 0x10..0x13, keep 0xFF, with m tready held at 1.
  - Output beats at T+2..T+5.
  - sop only on 0x10, eop only on 0x13.
  - tx_pkt_cnt goes 0→1.
- **Round robin:** all 3 requesters continuously valid with 2-beat packets.
  - Grant order is 0,1,2,0,1,2.
  - No interleaving; exactly one bubble between packets.
- **Backpressure:** toggle m tready with pattern 1,0,0,1,… during a 5-beat packet.
  - No beat lost or duplicated.
  - Output data held stable while stalled.
  - `s_axis_tready` low whenever the output is full and downstream is not ready.
- **Mid-packet gap and lock:** requester 1 drops valid for 3 cycles mid-packet while requester 2 is valid.
  - Grant stays on 1.
  - Requester 2 is served only after 1's tlast beat.
- **Single-beat packets:** requesters 0 and 2 each send 1-beat packets.
  - Each output beat has sop=eop=1.
  - Grant alternates 0,2.
  - tx_pkt_cnt increments per beat.
- **Reset mid-packet:** assert rst for 1 cycle during beat 2 of 4.
  - All outputs are 0 on the next cycle.
  - The next grant goes to requester 0 if valid.

Source files
------------

// File: rtl/egress_tx_arb.sv
// -----------------------------------------------------------------------------
// egress_tx_arb
//
// Packet-granular round-robin arbiter sharing the single PCIe transmit AXIS
// datapath among N_REQ internal TLP sources. A grant is held from the first
// beat of a packet until that packet's tlast beat is accepted, so TLPs are
// never interleaved. The output stage is a single register slice carrying
// sop/eop/tkeep in the same format the ingress side produces.
//
// Ports
//   clk               system clock (single domain)
//   rst               synchronous, active-high reset
//   s_axis_tvalid     per-requester beat valid                     [N_REQ]
//   s_axis_tready     per-requester ready, at most one bit high    [N_REQ]
//   s_axis_tdata      requester i at [i*DATA_W +: DATA_W]          [N_REQ*DATA_W]
//   s_axis_tkeep      requester i at [i*KEEP_W +: KEEP_W]          [N_REQ*KEEP_W]
//   s_axis_tlast      per-requester end-of-packet flag             [N_REQ]
//   m_axis_tx_tready  downstream ready
//   m_axis_tx_tvalid  output beat valid
//   m_axis_tx_tdata   output data                                  [DATA_W]
//   m_axis_tx_tkeep   output byte enables                          [KEEP_W]
//   m_axis_tx_sop     first beat of packet
//   m_axis_tx_eop     last beat of packet
//   arb_grant         one-hot current grant, zero when idle        [N_REQ]
//   arb_busy          high while a packet is being forwarded
//   tx_pkt_cnt        eop beats accepted downstream, wraps         [32]
// -----------------------------------------------------------------------------
module egress_tx_arb #(
    parameter int N_REQ  = 3,
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          s_axis_tvalid,
    output logic [N_REQ-1:0]          s_axis_tready,
    input  logic [N_REQ*DATA_W-1:0]   s_axis_tdata,
    input  logic [N_REQ*KEEP_W-1:0]   s_axis_tkeep,
    input  logic [N_REQ-1:0]          s_axis_tlast,
    input  logic                      m_axis_tx_tready,
    output logic                      m_axis_tx_tvalid,
    output logic [DATA_W-1:0]         m_axis_tx_tdata,
    output logic [KEEP_W-1:0]         m_axis_tx_tkeep,
    output logic                      m_axis_tx_sop,
    output logic                      m_axis_tx_eop,
    output logic [N_REQ-1:0]          arb_grant,
    output logic                      arb_busy,
    output logic [31:0]               tx_pkt_cnt
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [IDX_W-1:0]    last_grant_r;
    logic [IDX_W-1:0]    grant_idx_r;
    logic                first_beat_r;

    logic [IDX_W-1:0]    pick_idx_s;
    logic                pick_found_s;
    logic                out_free_s;
    logic                in_hs_s;
    logic                out_hs_s;
    logic [DATA_W-1:0]   in_data_s;
    logic [KEEP_W-1:0]   in_keep_s;
    logic                in_last_s;

    // Index reached by stepping 'step' positions upward from 'base' with wrap.
    // step is at most N_REQ and base below N_REQ, so one subtraction suffices.
    function automatic logic [IDX_W-1:0] rr_step(input logic [IDX_W-1:0] base,
                                                 input int               step);
        int sum_v;
        sum_v = int'(base) + step;
        if (sum_v >= N_REQ) begin
            sum_v = sum_v - N_REQ;
        end else begin
            sum_v = sum_v;
        end
        return IDX_W'(sum_v);
    endfunction

    // One-hot vector for a requester index.
    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh_v;
        oh_v = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (idx == IDX_W'(i)) begin
                oh_v[i] = 1'b1;
            end else begin
                oh_v[i] = 1'b0;
            end
        end
        return oh_v;
    endfunction

    // Round-robin search: first valid requester from last_grant+1 upward.
    always_comb begin
        pick_idx_s   = last_grant_r;
        pick_found_s = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!pick_found_s && s_axis_tvalid[rr_step(last_grant_r, k)]) begin
                pick_idx_s   = rr_step(last_grant_r, k);
                pick_found_s = 1'b1;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Select the granted requester's beat fields.
    always_comb begin
        in_data_s = '0;
        in_keep_s = '0;
        in_last_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx_r == IDX_W'(i)) begin
                in_data_s = s_axis_tdata[i*DATA_W +: DATA_W];
                in_keep_s = s_axis_tkeep[i*KEEP_W +: KEEP_W];
                in_last_s = s_axis_tlast[i];
            end else begin
                in_data_s = in_data_s;
                in_keep_s = in_keep_s;
                in_last_s = in_last_s;
            end
        end
    end

    // The output slot can take a beat when empty or draining this cycle;
    // this keeps a combinational path from downstream ready to tready.
    always_comb begin
        out_free_s = ~m_axis_tx_tvalid | m_axis_tx_tready;
        out_hs_s   = m_axis_tx_tvalid & m_axis_tx_tready;
        if (state_r == ST_BUSY) begin
            s_axis_tready = arb_grant & {N_REQ{out_free_s}};
        end else begin
            s_axis_tready = '0;
        end
        in_hs_s = |(s_axis_tready & s_axis_tvalid);
    end

    // Next-state logic: arbitrate in IDLE, leave BUSY on the accepted tlast beat.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (in_hs_s && in_last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Grant bookkeeping: capture winner in IDLE, release it on the tlast beat.
    // last_grant resets to the top index so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= LAST_IDX;
            grant_idx_r  <= '0;
            arb_grant    <= '0;
            arb_busy     <= 1'b0;
            first_beat_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        grant_idx_r  <= pick_idx_s;
                        arb_grant    <= idx_to_onehot(pick_idx_s);
                        arb_busy     <= 1'b1;
                        first_beat_r <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (in_hs_s) begin
                        first_beat_r <= 1'b0;
                        if (in_last_s) begin
                            arb_grant    <= '0;
                            arb_busy     <= 1'b0;
                            last_grant_r <= grant_idx_r;
                        end
                    end
                end
                default: begin
                    arb_grant <= '0;
                    arb_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output register slice: load on input handshake (reload wins over drain),
    // otherwise empty on downstream handshake; fields hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tx_tvalid <= 1'b0;
            m_axis_tx_tdata  <= '0;
            m_axis_tx_tkeep  <= '0;
            m_axis_tx_sop    <= 1'b0;
            m_axis_tx_eop    <= 1'b0;
        end else if (in_hs_s) begin
            m_axis_tx_tvalid <= 1'b1;
            m_axis_tx_tdata  <= in_data_s;
            m_axis_tx_tkeep  <= in_keep_s;
            m_axis_tx_sop    <= first_beat_r;
            m_axis_tx_eop    <= in_last_s;
        end else if (out_hs_s) begin
            m_axis_tx_tvalid <= 1'b0;
        end
    end

    // Packet counter: one per eop beat accepted downstream, free-running wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_pkt_cnt <= 32'd0;
        end else if (out_hs_s && m_axis_tx_eop) begin
            tx_pkt_cnt <= tx_pkt_cnt + 32'd1;
        end
    end

endmodule
